// File: rtl/ctrl_conta_pkg.sv
// Shared definitions for the phased modulo counter: state encoding, widths
// and the helper that picks the terminal value of the current phase.
package ctrl_conta_pkg;

  localparam int NUM_FASES     = 4;
  localparam int ANCHO_Q       = 3;
  localparam int ANCHO_VUELTAS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Terminal values are latched as one packed word, phase 0 in the low bits.
  function automatic logic [ANCHO_Q-1:0] sel_m(
    input logic [1:0]                   f,
    input logic [NUM_FASES*ANCHO_Q-1:0] tabla
  );
    return tabla[f*ANCHO_Q +: ANCHO_Q];
  endfunction

endpackage

// File: rtl/conta_mod_m.sv
// Modulo-(M+1) counter with a registered one-cycle wrap pulse.
// Counts only while enable is high; clear restarts it from zero.
module conta_mod_m
  import ctrl_conta_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               clear,
  input  logic [ANCHO_Q-1:0] M,
  output logic [ANCHO_Q-1:0] q,
  output logic               wrap
);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (enable) begin
      if (q == M) begin
        q    <= '0;
        wrap <= 1'b1;
      end else begin
        q    <= q + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_conta_fases.sv
// Four-phase sequencer around conta_mod_m; each phase wraps vueltas+1 times.
// Define CONTA_CICLICO_EN to loop back to phase 0 forever instead of finishing.
module ctrl_conta_fases
  import ctrl_conta_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     pause,
  input  logic [ANCHO_Q-1:0]       m0,
  input  logic [ANCHO_Q-1:0]       m1,
  input  logic [ANCHO_Q-1:0]       m2,
  input  logic [ANCHO_Q-1:0]       m3,
  input  logic [ANCHO_VUELTAS-1:0] vueltas,
  output logic [ANCHO_Q-1:0]       q,
  output logic [1:0]               fase,
  output logic                     busy,
  output logic                     wrap,
  output logic                     done
);

  estado_t                        estado;
  logic [NUM_FASES*ANCHO_Q-1:0]   m_lat;
  logic [ANCHO_VUELTAS-1:0]       vueltas_lat;
  logic [ANCHO_VUELTAS-1:0]       cuenta;
  logic [ANCHO_Q-1:0]             m_sel;
  logic                           enable;
  logic                           clear;
  logic                           fin_vuelta;

  assign m_sel      = sel_m(fase, m_lat);
  assign clear      = (estado == IDLE) && start;
  assign enable     = (estado == RUN) && !pause;
  assign fin_vuelta = enable && (q == m_sel);

  conta_mod_m u_conta (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .clear  (clear),
    .M      (m_sel),
    .q      (q),
    .wrap   (wrap)
  );

  // fin_vuelta mirrors the counter's own wrap decision for this same edge,
  // so phase bookkeeping stays aligned with the registered wrap pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      estado      <= IDLE;
      fase        <= 2'd0;
      cuenta      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      m_lat       <= '0;
      vueltas_lat <= '0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          if (start) begin
            estado      <= RUN;
            busy        <= 1'b1;
            fase        <= 2'd0;
            cuenta      <= '0;
            m_lat       <= {m3, m2, m1, m0};
            vueltas_lat <= vueltas;
          end
        end
        RUN: begin
          if (fin_vuelta) begin
            if (cuenta == vueltas_lat) begin
              cuenta <= '0;
              if (fase != 2'd3) begin
                fase <= fase + 2'd1;
              end else begin
`ifdef CONTA_CICLICO_EN
                fase <= 2'd0;
`else
                estado <= DONE;
                busy   <= 1'b0;
                done   <= 1'b1;
`endif
              end
            end else begin
              cuenta <= cuenta + 1'b1;
            end
          end
        end
        DONE: begin
          estado <= IDLE;
        end
        default: begin
          estado <= IDLE;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_conta_fases.sv
// Randomised check of ctrl_conta_fases against a model that derives q/fase
// from the number of counting edges elapsed, plus a few fixed sequences.
module tb_ctrl_conta_fases;

  logic       clk = 1'b0;
  logic       reset, start, pause;
  logic [2:0] m0, m1, m2, m3;
  logic [3:0] vueltas;
  logic [2:0] q;
  logic [1:0] fase;
  logic       busy, wrap, done;

  int total_cmp = 0;
  int bad_cmp   = 0;

  always #5 clk = ~clk;

  ctrl_conta_fases dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pause   (pause),
    .m0      (m0),
    .m1      (m1),
    .m2      (m2),
    .m3      (m3),
    .vueltas (vueltas),
    .q       (q),
    .fase    (fase),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done)
  );

  // Model state: 0 idle, 1 running, 2 finished; mod_k counts counting edges.
  int mod_st = 0;
  int mod_m[4];
  int mod_v, mod_k, mod_total;
  int exp_q = 0, exp_fase = 0, exp_wrap = 0, exp_done = 0;

  int q_hist[32];
  int fase_hist[32];
  int wrap_hist[32];
  int done_edge;

  function automatic int largo_fase(int f);
    return (mod_m[f] + 1) * (mod_v + 1);
  endfunction

  function automatic int inicio_de(int f);
    int acc = 0;
    for (int i = 0; i < f; i++) acc += largo_fase(i);
    return acc;
  endfunction

  function automatic int fase_de(int k);
    for (int i = 0; i < 4; i++)
      if (k < inicio_de(i) + largo_fase(i)) return i;
    return 3;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_cmp++;
    if (actual !== expected) begin
      bad_cmp++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic s, input logic p);
    int f, off;
    exp_wrap = 0;
    exp_done = 0;
    if (!r) begin
      mod_st   = 0;
      exp_q    = 0;
      exp_fase = 0;
    end else begin
      case (mod_st)
        0: if (s) begin
          mod_m[0] = int'(m0); mod_m[1] = int'(m1);
          mod_m[2] = int'(m2); mod_m[3] = int'(m3);
          mod_v     = int'(vueltas);
          mod_total = inicio_de(4);
          mod_k     = 0;
          mod_st    = 1;
          exp_q     = 0;
          exp_fase  = 0;
        end
        1: if (!p) begin
          f   = fase_de(mod_k);
          off = mod_k - inicio_de(f);
          exp_wrap = ((off % (mod_m[f] + 1)) == mod_m[f]) ? 1 : 0;
          mod_k++;
          if (mod_k == mod_total) begin
`ifdef CONTA_CICLICO_EN
            mod_k    = 0;
            exp_q    = 0;
            exp_fase = 0;
`else
            mod_st   = 2;
            exp_done = 1;
            exp_q    = 0;
            exp_fase = 3;
`endif
          end else begin
            f        = fase_de(mod_k);
            exp_fase = f;
            exp_q    = (mod_k - inicio_de(f)) % (mod_m[f] + 1);
          end
        end
        default: mod_st = 0;
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic p);
    reset = r;
    start = s;
    pause = p;
    @(posedge clk);
    modelStep(r, s, p);
    #1;
    checkOutput("q",    32'(q),    exp_q);
    checkOutput("fase", 32'(fase), exp_fase);
    checkOutput("busy", 32'(busy), (mod_st == 1) ? 1 : 0);
    checkOutput("wrap", 32'(wrap), exp_wrap);
    checkOutput("done", 32'(done), exp_done);
  endtask

  // Start edge is edge 0; records outputs after each of the following edges.
  task automatic runSeq(input int n, input int pausa_desde, input int pausa_largo);
    done_edge = -1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    q_hist[0] = int'(q); fase_hist[0] = int'(fase); wrap_hist[0] = int'(wrap);
    for (int e = 1; e <= n; e++) begin
      applyStimulus(1'b1, 1'b0, (e >= pausa_desde && e < pausa_desde + pausa_largo));
      q_hist[e] = int'(q); fase_hist[e] = int'(fase); wrap_hist[e] = int'(wrap);
      if (done === 1'b1 && done_edge < 0) done_edge = e;
    end
  endtask

  task automatic setM(input int a, input int b, input int c, input int d, input int v);
    m0 = 3'(a); m1 = 3'(b); m2 = 3'(c); m3 = 3'(d); vueltas = 4'(v);
  endtask

  initial begin
    int wraps;
    int guard;
    setM(0, 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);

`ifndef CONTA_CICLICO_EN
    setM(1, 2, 0, 3, 0);
    runSeq(12, 99, 0);
    checkOutput("done_edge", 32'(done_edge), 10);
    checkOutput("fase_e1", 32'(fase_hist[1]), 0);
    checkOutput("fase_e2", 32'(fase_hist[2]), 1);
    checkOutput("fase_e4", 32'(fase_hist[4]), 1);
    checkOutput("fase_e5", 32'(fase_hist[5]), 2);
    checkOutput("fase_e6", 32'(fase_hist[6]), 3);

    setM(2, 1, 1, 1, 2);
    runSeq(9, 99, 0);
    wraps = 0;
    for (int e = 0; e <= 9; e++) begin
      checkOutput("q_seq", 32'(q_hist[e]), 32'((e % 3 == 0) ? 0 : (e % 3)));
      if (e > 0) wraps += wrap_hist[e];
    end
    checkOutput("wraps3", 32'(wraps), 3);
    checkOutput("fase_e9", 32'(fase_hist[9]), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);

    setM(1, 2, 0, 3, 0);
    runSeq(16, 2, 4);
    checkOutput("q_paused", 32'(q_hist[4]), 1);
    checkOutput("done_paused", 32'(done_edge), 14);

    setM(1, 2, 0, 3, 0);
    runSeq(2, 99, 0);
    m0 = 3'd7;
    applyStimulus(1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort_q", 32'(q), 0);
    checkOutput("abort_busy", 32'(busy), 0);
`else
    setM(0, 0, 0, 0, 0);
    runSeq(8, 99, 0);
    for (int e = 1; e <= 8; e++) begin
      checkOutput("cyc_fase", 32'(fase_hist[e]), 32'(e % 4));
      checkOutput("cyc_wrap", 32'(wrap_hist[e]), 1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
`endif

    for (int s = 0; s < 40; s++) begin
      setM($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 3));
      applyStimulus(1'b1, 1'b1, ($urandom_range(0, 3) == 0));
      guard = 0;
      while (mod_st != 0 && guard < 600) begin
        if ($urandom_range(0, 9) == 0) m0 = 3'($urandom_range(0, 7));
        applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
                      ($urandom_range(0, 4) == 0));
        guard++;
      end
`ifdef CONTA_CICLICO_EN
      applyStimulus(1'b0, 1'b0, 1'b0);
`endif
      applyStimulus(1'b1, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total_cmp, bad_cmp);
    $finish;
  end

endmodule
